dma_ahb_sub: RTL and testbench
==============================

DMA_AHB_SUB -- requirements
Module: dma_ahb_sub

Interface
- REQ-001: Parameters SHALL be:
  - ADDR_WIDTH, 32, HADDR width.
  - DEPTH, 1024, number of 32-bit memory words; power of two.
  - WAIT_STATES, 0, wait cycles inserted per OKAY data phase; range 0..15.
- REQ-002: Ports SHALL be, in order:
  - clk_i  in  1  single clock; all logic on rising edge.
  - rst_i  in  1  asynchronous, active-high reset.
  - hsel_i  in  1  subordinate select.
  - haddr_i  in  ADDR_WIDTH  byte address.
  - htrans_i  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
  - hwrite_i  in  1  1 = write.
  - hsize_i  in  3  0 = byte, 1 = half, 2 = word.
  - hburst_i  in  3  ignored.
  - hwdata_i  in  32  write data, data phase.
  - hready_i  in  1  bus-level HREADY.
  - hrdata_o  out  32  read data.
  - hreadyout_o  out  1  subordinate ready.
  - hresp_o  out  1  0 = OKAY, 1 = ERROR.
- REQ-003: The block SHALL have one clock and an asynchronous, active-high reset (clk_i, rst_i).

Function
- REQ-004: A transfer SHALL be accepted on a rising edge where hsel_i & htrans_i[1] & hready_i = 1. On acceptance, haddr_i, hwrite_i and hsize_i SHALL be latched.
- REQ-005: IDLE/BUSY, unselected, or hready_i = 0 cycles SHALL be ignored. A subordinate with no transfer pending SHALL drive hreadyout_o = 1 and hresp_o = 0.
- REQ-006: The FSM SHALL have states IDLE, WAIT, DATA, ERR1, ERR2.
- REQ-007: On acceptance, the next state SHALL be:
  - ERR1 if the transfer is illegal;
  - WAIT if WAIT_STATES > 0;
  - DATA otherwise.
- REQ-008: A transfer SHALL be illegal if any of the following holds:
  - haddr[ADDR_WIDTH-1:2] >= DEPTH;
  - hsize_i > 2;
  - halfword with addr[0] = 1;
  - word with addr[1:0] != 0.
- REQ-009: WAIT SHALL drive hreadyout_o = 0 for exactly WAIT_STATES cycles, counted by a 4-bit down-counter, then go to DATA.
- REQ-010: DATA SHALL drive hreadyout_o = 1 and hresp_o = 0 for one cycle. At that cycle's edge, the next state SHALL be:
  - WAIT, DATA or ERR1 if a new transfer is accepted;
  - IDLE otherwise.
- REQ-011: The ERROR response SHALL take two cycles:
  - ERR1: hresp_o = 1, hreadyout_o = 0.
  - ERR2: hresp_o = 1, hreadyout_o = 1.
  - ERR2 SHALL permit acceptance of a new transfer, exactly like DATA.
- REQ-012: An ERROR transfer SHALL NOT modify memory and SHALL drive hrdata_o = 0.
- REQ-013: A write SHALL update memory at the end of its DATA cycle, using byte lanes decoded from the latched size and addr[1:0]:
  - byte: one lane;
  - half: lanes {1,0} or {3,2};
  - word: all lanes.
  - Other lanes SHALL be unchanged.
- REQ-014: A read SHALL present the full addressed 32-bit word on hrdata_o during its DATA cycle, independent of size. hrdata_o SHALL be 0 in all other cycles.
- REQ-015: A read whose data phase immediately follows a write data phase to the same word SHALL return the post-write value (forwarding, no added wait).
- REQ-016: Back-to-back accepted transfers with WAIT_STATES = 0 SHALL complete one per cycle, with no bubble.
- REQ-017: Address-phase signals presented while hreadyout_o = 0 SHALL NOT be sampled.

Reset
- REQ-018: While rst_i = 1, the block SHALL be asynchronously reset:
  - state = IDLE;
  - wait counter = 0;
  - hreadyout_o = 1;
  - hresp_o = 0;
  - hrdata_o = 0.
- REQ-019: A reset asserted mid-transfer SHALL discard the pending transfer, with no memory write. Memory contents SHALL NOT be reset.
- REQ-020: After rst_i deassertion, the first rising edge SHALL be able to accept a transfer.

Verification
- REQ-021: With WAIT_STATES = 0, a word write of 0xDEADBEEF to 0x10 followed back-to-back by a read of 0x10 -> read DATA cycle gives hrdata_o = 0xDEADBEEF, hreadyout_o = 1 every cycle, hresp_o = 0.
- REQ-022: Word 0x14 = 0x11223344, then a byte write of 0xAA on lane 2 (addr 0x16), then a word read -> 0x11AA3344.
- REQ-023: With WAIT_STATES = 3, a read -> hreadyout_o low for exactly 3 cycles, then high with valid data.
- REQ-024: A word access at 0x1002 (misaligned), and separately at word index DEPTH -> ERR1 (hresp_o = 1, hreadyout_o = 0), then ERR2 (hresp_o = 1, hreadyout_o = 1); memory unchanged; hrdata_o = 0.
- REQ-025: rst_i asserted during WAIT of a write to 0x20 (old value 0x0) -> outputs return to reset values immediately, and a later read of 0x20 returns 0x0.
- REQ-026: An IDLE transfer, and a NONSEQ with hsel_i = 0 -> hreadyout_o = 1, hresp_o = 0, no memory change.

Source files
------------

// File: rtl/dma_ahb_sub.sv
// AHB subordinate: word-organised SRAM with byte-lane writes, optional wait
// states and a two-cycle ERROR response for out-of-range or misaligned accesses.
module dma_ahb_sub #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  hsel_i,
    input  logic [ADDR_WIDTH-1:0] haddr_i,
    input  logic [1:0]            htrans_i,
    input  logic                  hwrite_i,
    input  logic [2:0]            hsize_i,
    input  logic [2:0]            hburst_i,
    input  logic [31:0]           hwdata_i,
    input  logic                  hready_i,
    output logic [31:0]           hrdata_o,
    output logic                  hreadyout_o,
    output logic                  hresp_o
);

    localparam int          IW      = $clog2(DEPTH);
    localparam logic [3:0]  WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [3:0]      r_wcnt;
    logic [IW+1:0]   r_addr;
    logic            r_write;
    logic [2:0]      r_size;
    logic [31:0]     r_mem [DEPTH];

    logic            w_open;
    logic            w_accept;
    logic            w_illegal;
    logic            w_wr_data;
    logic [IW-1:0]   w_idx;
    logic [3:0]      w_be;
    logic            w_unused;

    // Burst type and the BUSY/IDLE distinction carry no information here.
    assign w_unused = ^{htrans_i[0], hburst_i};

    // A new address phase is only sampled while this subordinate shows ready.
    assign w_open    = (r_state == S_IDLE) || (r_state == S_DATA) || (r_state == S_ERR2);
    assign w_accept  = w_open && hsel_i && htrans_i[1] && hready_i;
    assign w_illegal = (|haddr_i[ADDR_WIDTH-1:IW+2])
                     || (hsize_i > 3'd2)
                     || ((hsize_i == 3'd1) && haddr_i[0])
                     || ((hsize_i == 3'd2) && (|haddr_i[1:0]));
    assign w_idx     = r_addr[IW+1:2];
    assign w_wr_data = (r_state == S_DATA) && r_write;

    // State register and latched address phase.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_size  <= 3'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr  <= haddr_i[IW+1:0];
                r_write <= hwrite_i;
                r_size  <= hsize_i;
            end
        end
    end

    // Wait-state down-counter: loaded on a legal accept, runs down in WAIT.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wcnt <= 4'd0;
        end else if (w_accept && !w_illegal) begin
            r_wcnt <= WS_LOAD;
        end else if ((r_state == S_WAIT) && (r_wcnt != 4'd0)) begin
            r_wcnt <= r_wcnt - 4'd1;
        end
    end

    // Next-state decode; DATA and ERR2 chain straight into the next transfer.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DATA, S_ERR2: begin
                if (w_accept) begin
                    if (w_illegal)            w_next = S_ERR1;
                    else if (WAIT_STATES > 0) w_next = S_WAIT;
                    else                      w_next = S_DATA;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_WAIT:  if (r_wcnt == 4'd0) w_next = S_DATA;
            S_ERR1:  w_next = S_ERR2;
            default: w_next = S_IDLE;
        endcase
    end

    // Bus response; read data is combinational so a write retired on the
    // previous edge is already visible to a following read.
    always_comb begin
        hreadyout_o = !((r_state == S_WAIT) || (r_state == S_ERR1));
        hresp_o     = (r_state == S_ERR1) || (r_state == S_ERR2);
        hrdata_o    = 32'h0;
        if ((r_state == S_DATA) && !r_write) hrdata_o = r_mem[w_idx];
    end

    // Byte-lane enables from latched size and low address bits.
    always_comb begin
        w_be = 4'b0000;
        case (r_size)
            3'd0:    w_be[r_addr[1:0]] = 1'b1;
            3'd1:    w_be = r_addr[1] ? 4'b1100 : 4'b0011;
            3'd2:    w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    // Memory array, not reset; writes retire at the end of the DATA cycle.
    always_ff @(posedge clk_i) begin
        if (w_wr_data) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= hwdata_i[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dma_ahb_sub.sv
// Directed bench: dut0 has no wait states, dut3 has three. Bus inputs are
// shared; per-DUT hsel picks the target.
module tb_dma_ahb_sub;

    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NSEQ = 2'd2;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsel0, hsel3, hrdy0, hrdy3, hwrite;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [2:0]  hburst = 3'd0;
    logic [31:0] rdata0, rdata3;
    logic        rdy0, rdy3, resp0, resp3;
    logic [33:0] obs0, obs3, exp_v;
    int          n_cmp = 0;
    int          n_bad = 0;

    assign obs0 = {rdy0, resp0, rdata0};
    assign obs3 = {rdy3, resp3, rdata3};

    always #5 clk = ~clk;

    dma_ahb_sub #(.ADDR_WIDTH(32), .DEPTH(1024), .WAIT_STATES(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .hsel_i(hsel0), .haddr_i(haddr), .htrans_i(htrans),
        .hwrite_i(hwrite), .hsize_i(hsize), .hburst_i(hburst), .hwdata_i(hwdata),
        .hready_i(hrdy0), .hrdata_o(rdata0), .hreadyout_o(rdy0), .hresp_o(resp0));

    dma_ahb_sub #(.ADDR_WIDTH(32), .DEPTH(1024), .WAIT_STATES(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .hsel_i(hsel3), .haddr_i(haddr), .htrans_i(htrans),
        .hwrite_i(hwrite), .hsize_i(hsize), .hburst_i(hburst), .hwdata_i(hwdata),
        .hready_i(hrdy3), .hrdata_o(rdata3), .hreadyout_o(rdy3), .hresp_o(resp3));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Address phase for the next transfer plus write data for the current one.
    task automatic drv(input logic s0, input logic s3, input logic [1:0] tr, input logic [31:0] a,
                       input logic w, input logic [2:0] sz, input logic [31:0] wd);
        hsel0 = s0; hsel3 = s3; htrans = tr; haddr = a; hwrite = w; hsize = sz; hwdata = wd;
    endtask

    task automatic test_reset;
        rst = 1'b1; hrdy0 = 1'b1; hrdy3 = 1'b1;
        drv(0, 0, IDLE, 32'h0, 0, 3'd2, 32'h0);
        repeat (2) tick();
        exp_v = {2'b10, 32'h0};
        n_cmp++; if (obs0 !== exp_v) begin n_bad++; $display("FAIL reset0: got %h want %h", obs0, exp_v); end
        n_cmp++; if (obs3 !== exp_v) begin n_bad++; $display("FAIL reset3: got %h want %h", obs3, exp_v); end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back;
        drv(1, 0, NSEQ, 32'h10, 1, 3'd2, 32'h0);
        tick();
        exp_v = {2'b10, 32'h0};
        n_cmp++; if (obs0 !== exp_v) begin n_bad++; $display("FAIL b2b_wr: got %h want %h", obs0, exp_v); end
        drv(1, 0, NSEQ, 32'h10, 0, 3'd2, 32'hDEADBEEF);
        tick();
        exp_v = {2'b10, 32'hDEADBEEF};
        n_cmp++; if (obs0 !== exp_v) begin n_bad++; $display("FAIL b2b_rd: got %h want %h", obs0, exp_v); end
        drv(0, 0, IDLE, 32'h0, 0, 3'd2, 32'h0);
        tick();
        exp_v = {2'b10, 32'h0};
        n_cmp++; if (obs0 !== exp_v) begin n_bad++; $display("FAIL b2b_idle: got %h want %h", obs0, exp_v); end
    endtask

    task automatic test_byte_lanes;
        drv(1, 0, NSEQ, 32'h14, 1, 3'd2, 32'h0);
        tick();
        drv(1, 0, NSEQ, 32'h16, 1, 3'd0, 32'h11223344);
        tick();
        drv(1, 0, NSEQ, 32'h14, 0, 3'd2, 32'h00AA0000);
        tick();
        exp_v = {2'b10, 32'h11AA3344};
        n_cmp++; if (obs0 !== exp_v) begin n_bad++; $display("FAIL byte_lane2: got %h want %h", obs0, exp_v); end
        drv(1, 0, NSEQ, 32'h18, 1, 3'd2, 32'h0);
        tick();
        drv(1, 0, NSEQ, 32'h1A, 1, 3'd1, 32'h55667788);
        tick();
        // byte-sized read still returns the whole word
        drv(1, 0, NSEQ, 32'h19, 0, 3'd0, 32'hBEEF0000);
        tick();
        exp_v = {2'b10, 32'hBEEF7788};
        n_cmp++; if (obs0 !== exp_v) begin n_bad++; $display("FAIL half_upper: got %h want %h", obs0, exp_v); end
        drv(0, 0, IDLE, 32'h0, 0, 3'd2, 32'h0);
        tick();
    endtask

    task automatic test_error;
        drv(1, 0, NSEQ, 32'h1002, 1, 3'd2, 32'h0);
        tick();
        exp_v = {2'b01, 32'h0};
        n_cmp++; if (obs0 !== exp_v) begin n_bad++; $display("FAIL err_mis_e1: got %h want %h", obs0, exp_v); end
        drv(1, 0, NSEQ, 32'h10, 0, 3'd2, 32'hFFFFFFFF);
        tick();
        exp_v = {2'b11, 32'h0};
        n_cmp++; if (obs0 !== exp_v) begin n_bad++; $display("FAIL err_mis_e2: got %h want %h", obs0, exp_v); end
        drv(1, 0, NSEQ, 32'h1000, 1, 3'd2, 32'hFFFFFFFF);
        tick();
        exp_v = {2'b01, 32'h0};
        n_cmp++; if (obs0 !== exp_v) begin n_bad++; $display("FAIL err_range_e1: got %h want %h", obs0, exp_v); end
        drv(0, 0, IDLE, 32'h0, 0, 3'd2, 32'hFFFFFFFF);
        tick();
        exp_v = {2'b11, 32'h0};
        n_cmp++; if (obs0 !== exp_v) begin n_bad++; $display("FAIL err_range_e2: got %h want %h", obs0, exp_v); end
        drv(1, 0, NSEQ, 32'h11, 1, 3'd1, 32'h0);
        tick();
        exp_v = {2'b01, 32'h0};
        n_cmp++; if (obs0 !== exp_v) begin n_bad++; $display("FAIL err_half_e1: got %h want %h", obs0, exp_v); end
        drv(0, 0, IDLE, 32'h0, 0, 3'd2, 32'h12345678);
        tick();
        drv(1, 0, NSEQ, 32'h10, 0, 3'd2, 32'h12345678);
        tick();
        exp_v = {2'b10, 32'hDEADBEEF};
        n_cmp++; if (obs0 !== exp_v) begin n_bad++; $display("FAIL err_mem_kept: got %h want %h", obs0, exp_v); end
        drv(0, 0, IDLE, 32'h0, 0, 3'd2, 32'h0);
        tick();
    endtask

    task automatic test_wait_states;
        drv(0, 1, NSEQ, 32'h30, 1, 3'd2, 32'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            exp_v = {2'b00, 32'h0};
            n_cmp++; if (obs3 !== exp_v) begin n_bad++; $display("FAIL wait_wr%0d: got %h want %h", i, obs3, exp_v); end
            // address phase presented while stalled must be ignored
            drv(0, 1, NSEQ, 32'h34, 1, 3'd0, 32'hCAFEF00D);
            tick();
        end
        exp_v = {2'b10, 32'h0};
        n_cmp++; if (obs3 !== exp_v) begin n_bad++; $display("FAIL wait_wr_data: got %h want %h", obs3, exp_v); end
        drv(0, 1, NSEQ, 32'h30, 0, 3'd2, 32'hCAFEF00D);
        tick();
        for (int i = 0; i < 3; i++) begin
            exp_v = {2'b00, 32'h0};
            n_cmp++; if (obs3 !== exp_v) begin n_bad++; $display("FAIL wait_rd%0d: got %h want %h", i, obs3, exp_v); end
            drv(0, 0, IDLE, 32'h0, 0, 3'd2, 32'h0);
            tick();
        end
        exp_v = {2'b10, 32'hCAFEF00D};
        n_cmp++; if (obs3 !== exp_v) begin n_bad++; $display("FAIL wait_rd_data: got %h want %h", obs3, exp_v); end
        tick();
        exp_v = {2'b10, 32'h0};
        n_cmp++; if (obs3 !== exp_v) begin n_bad++; $display("FAIL wait_idle: got %h want %h", obs3, exp_v); end
    endtask

    task automatic test_reset_mid;
        drv(0, 1, NSEQ, 32'h20, 1, 3'd2, 32'h0);
        tick();
        drv(0, 0, IDLE, 32'h0, 0, 3'd2, 32'h0);
        repeat (4) tick();
        drv(0, 1, NSEQ, 32'h20, 1, 3'd2, 32'h0);
        tick();
        exp_v = {2'b00, 32'h0};
        n_cmp++; if (obs3 !== exp_v) begin n_bad++; $display("FAIL rstmid_wait: got %h want %h", obs3, exp_v); end
        drv(0, 0, IDLE, 32'h0, 0, 3'd2, 32'h5A5A5A5A);
        #2 rst = 1'b1;
        #1;
        exp_v = {2'b10, 32'h0};
        n_cmp++; if (obs3 !== exp_v) begin n_bad++; $display("FAIL rstmid_async: got %h want %h", obs3, exp_v); end
        tick();
        rst = 1'b0;
        drv(0, 1, NSEQ, 32'h20, 0, 3'd2, 32'h5A5A5A5A);
        tick();
        drv(0, 0, IDLE, 32'h0, 0, 3'd2, 32'h5A5A5A5A);
        repeat (3) tick();
        exp_v = {2'b10, 32'h0};
        n_cmp++; if (obs3 !== exp_v) begin n_bad++; $display("FAIL rstmid_rd: got %h want %h", obs3, exp_v); end
        n_cmp++; if (rdy3 !== 1'b1) begin n_bad++; $display("FAIL rstmid_rdy: got %b want 1", rdy3); end
        tick();
    endtask

    task automatic test_ignore;
        drv(1, 0, NSEQ, 32'h40, 1, 3'd2, 32'h0);
        tick();
        drv(1, 0, IDLE, 32'h40, 1, 3'd2, 32'h01020304);
        tick();
        exp_v = {2'b10, 32'h0};
        n_cmp++; if (obs0 !== exp_v) begin n_bad++; $display("FAIL ign_idle: got %h want %h", obs0, exp_v); end
        drv(0, 0, NSEQ, 32'h40, 1, 3'd2, 32'hFFFFFFFF);
        tick();
        n_cmp++; if (obs0 !== exp_v) begin n_bad++; $display("FAIL ign_nosel: got %h want %h", obs0, exp_v); end
        hrdy0 = 1'b0;
        drv(1, 0, NSEQ, 32'h40, 1, 3'd2, 32'hFFFFFFFF);
        tick();
        hrdy0 = 1'b1;
        n_cmp++; if (obs0 !== exp_v) begin n_bad++; $display("FAIL ign_nordy: got %h want %h", obs0, exp_v); end
        drv(1, 0, BUSY, 32'h40, 1, 3'd2, 32'hFFFFFFFF);
        tick();
        n_cmp++; if (obs0 !== exp_v) begin n_bad++; $display("FAIL ign_busy: got %h want %h", obs0, exp_v); end
        drv(1, 0, NSEQ, 32'h40, 0, 3'd2, 32'hFFFFFFFF);
        tick();
        exp_v = {2'b10, 32'h01020304};
        n_cmp++; if (obs0 !== exp_v) begin n_bad++; $display("FAIL ign_mem: got %h want %h", obs0, exp_v); end
        drv(0, 0, IDLE, 32'h0, 0, 3'd2, 32'h0);
        tick();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_byte_lanes();
        test_error();
        test_wait_states();
        test_reset_mid();
        test_ignore();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
